// File: rtl/audio_deserializer.sv
// rtl/audio_deserializer.sv - I2S ADC deserializer producing registered {left,right} sample pairs
// Optional saturating error counter output ERR_CNT enabled by macro AUDIO_DESERIALIZER_ERRCNT_EN.
module audio_deserializer #(
    parameter int DATA_W = 16
) (
    input  logic                BCLK,
    input  logic                RST_N,
    input  logic                ADCLRCK,
    input  logic                ADCDAT,
    output logic [2*DATA_W-1:0] ADCDAT_PAR,
    output logic                PAR_VALID,
    output logic                FRAME_ERR
`ifdef AUDIO_DESERIALIZER_ERRCNT_EN
    ,
    output logic [7:0]          ERR_CNT
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT_L = 3'd1,
        WAIT_L  = 3'd2,
        SHIFT_R = 3'd3,
        WAIT_R  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                lr_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   sr_l_q, sr_l_d;
    logic [DATA_W-1:0]   sr_r_q, sr_r_d;
    logic                pend_q, pend_d;
    logic [2*DATA_W-1:0] par_q, par_d;
    logic                par_valid_q;
    logic                frame_err_q;

    logic lr_edge, lr_rise, lr_fall, last_bit;
    logic shift_l, shift_r, start_word, short_word, right_done;

    assign lr_edge  = ADCLRCK ^ lr_q;
    assign lr_rise  = lr_edge & ADCLRCK;
    assign lr_fall  = lr_edge & ~ADCLRCK;
    assign last_bit = (cnt_q == LAST_CNT);

    always_ff @(posedge BCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A frame-clock edge landing on the final sample completes the word and
    // immediately opens the next channel, so 16-slot frames lose no edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (lr_fall) state_d = SHIFT_L;
            end
            SHIFT_L: begin
                if (last_bit) begin
                    state_d = lr_rise ? SHIFT_R : WAIT_L;
                end else if (lr_edge) begin
                    state_d = lr_fall ? SHIFT_L : IDLE;
                end
            end
            WAIT_L: begin
                if (lr_rise) state_d = SHIFT_R;
            end
            SHIFT_R: begin
                if (last_bit) begin
                    state_d = lr_fall ? SHIFT_L : WAIT_R;
                end else if (lr_edge) begin
                    state_d = lr_fall ? SHIFT_L : IDLE;
                end
            end
            WAIT_R: begin
                if (lr_fall) state_d = SHIFT_L;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_l = 1'b0;
        shift_r = 1'b0;
        unique case (state_q)
            SHIFT_L: shift_l = 1'b1;
            SHIFT_R: shift_r = 1'b1;
            default: ;
        endcase
        short_word = (shift_l | shift_r) & lr_edge & ~last_bit;
        right_done = shift_r & last_bit;
        start_word = lr_edge & ((state_d == SHIFT_L) || (state_d == SHIFT_R));
    end

    // The pair is published one edge after the right LSB; the left register may
    // already be taking the next frame's MSB on that same edge.
    always_comb begin
        sr_l_d = sr_l_q;
        sr_r_d = sr_r_q;
        cnt_d  = cnt_q;
        if (shift_l) sr_l_d = {sr_l_q[DATA_W-2:0], ADCDAT};
        if (shift_r) sr_r_d = {sr_r_q[DATA_W-2:0], ADCDAT};
        if (start_word) begin
            cnt_d = '0;
        end else if (shift_l || shift_r) begin
            cnt_d = last_bit ? FULL_CNT : cnt_q + CNT_W'(1);
        end
        pend_d = right_done;
        par_d  = pend_q ? {sr_l_q, sr_r_q} : par_q;
    end

    always_ff @(posedge BCLK or negedge RST_N) begin
        if (!RST_N) begin
            lr_q        <= 1'b0;
            cnt_q       <= '0;
            sr_l_q      <= '0;
            sr_r_q      <= '0;
            pend_q      <= 1'b0;
            par_q       <= '0;
            par_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            lr_q        <= ADCLRCK;
            cnt_q       <= cnt_d;
            sr_l_q      <= sr_l_d;
            sr_r_q      <= sr_r_d;
            pend_q      <= pend_d;
            par_q       <= par_d;
            par_valid_q <= pend_q;
            frame_err_q <= short_word;
        end
    end

    assign ADCDAT_PAR = par_q;
    assign PAR_VALID  = par_valid_q;
    assign FRAME_ERR  = frame_err_q;

`ifdef AUDIO_DESERIALIZER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (short_word && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge BCLK or negedge RST_N) begin
        if (!RST_N) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_audio_deserializer.sv
// tb/tb_audio_deserializer.sv - self-checking bench for audio_deserializer with a frame-level reference model
module tb_audio_deserializer;

    localparam int W = 16;

    logic           BCLK    = 1'b0;
    logic           RST_N   = 1'b0;
    logic           ADCLRCK = 1'b0;
    logic           ADCDAT  = 1'b0;
    logic [2*W-1:0] ADCDAT_PAR;
    logic           PAR_VALID;
    logic           FRAME_ERR;
`ifdef AUDIO_DESERIALIZER_ERRCNT_EN
    logic [7:0]     ERR_CNT;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_err  = 0;
    int exp_err = 0;
    logic prev_d   = 1'b0;
    logic model_lr = 1'b0;
    logic [2*W-1:0] par_hold = '0;
    logic [2*W-1:0] exp_par_q[$];
    int             exp_cyc_q[$];

    logic [W-1:0] rl, rr;
    int ls, rs, mode, s;

    always #5 BCLK = ~BCLK;

    audio_deserializer #(.DATA_W(W)) dut (
        .BCLK      (BCLK),
        .RST_N     (RST_N),
        .ADCLRCK   (ADCLRCK),
        .ADCDAT    (ADCDAT),
        .ADCDAT_PAR(ADCDAT_PAR),
        .PAR_VALID (PAR_VALID),
        .FRAME_ERR (FRAME_ERR)
`ifdef AUDIO_DESERIALIZER_ERRCNT_EN
        ,
        .ERR_CNT   (ERR_CNT)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One BCLK slot: frame clock changes now, data lags it by one slot (I2S).
    task automatic drive_slot(input logic lr, input logic d);
        @(negedge BCLK);
        ADCLRCK = lr;
        ADCDAT  = prev_d;
        prev_d  = d;
        @(posedge BCLK);
        cyc++;
        #1;
        model_lr = RST_N ? lr : 1'b0;
        if (PAR_VALID === 1'b1) begin
            chk("unexpected_valid", 64'(exp_par_q.size() > 0), 64'd1);
            if (exp_par_q.size() > 0) begin
                chk("valid_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
                chk("par_data", 64'(ADCDAT_PAR), 64'(exp_par_q.pop_front()));
            end
            par_hold = ADCDAT_PAR;
        end else begin
            chk("par_hold", 64'(ADCDAT_PAR), 64'(par_hold));
        end
        if (FRAME_ERR === 1'b1) n_err++;
    endtask

    // A pair is output only if its left slot opens on a falling edge and both
    // channels last at least W slots; otherwise a synced frame yields one error.
    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                              input int l_slots, input int r_slots, input logic fill);
        logic synced;
        int   k_r;
        synced = model_lr;
        k_r    = cyc + l_slots + 1;
        if (synced) begin
            if (l_slots < W || r_slots < W) begin
                exp_err++;
            end else begin
                exp_par_q.push_back({l, r});
                exp_cyc_q.push_back(k_r + W + 1);
            end
        end
        for (int j = 0; j < l_slots; j++) drive_slot(1'b0, (j < W) ? l[W-1-j] : fill);
        for (int j = 0; j < r_slots; j++) drive_slot(1'b1, (j < W) ? r[W-1-j] : fill);
    endtask

    task automatic flush();
        for (int j = 0; j < W + 4; j++) drive_slot(1'b1, 1'b0);
    endtask

    task automatic end_check(input string tag);
        chk({tag, "_frame_err_count"}, 64'(n_err), 64'(exp_err));
        chk({tag, "_pairs_outstanding"}, 64'(exp_par_q.size()), 64'd0);
    endtask

    initial begin
        for (int j = 0; j < 3; j++) drive_slot(1'b0, 1'b0);
        chk("reset_par", 64'(ADCDAT_PAR), 64'd0);
        chk("reset_valid", 64'(PAR_VALID), 64'd0);
        chk("reset_err", 64'(FRAME_ERR), 64'd0);
        RST_N = 1'b1;
        for (int j = 0; j < 3; j++) drive_slot(1'b1, 1'b0);

        send_frame(16'hA5C3, 16'h1234, 16, 16, 1'b0);
        send_frame(W'($urandom()), W'($urandom()), 16, 16, 1'b0);
        flush();
        end_check("basic16");

        send_frame(16'h8001, 16'h7FFE, 32, 32, 1'b1);
        send_frame(16'h8001, 16'h7FFE, 32, 32, 1'b1);
        flush();
        end_check("slot32");

        send_frame(W'($urandom()), W'($urandom()), 16, 11, 1'b0);
        send_frame(W'($urandom()), W'($urandom()), 16, 16, 1'b0);
        flush();
        end_check("short_right");

        for (int i = 0; i < 24; i++) begin
            rl   = W'($urandom());
            rr   = W'($urandom());
            mode = int'($urandom_range(0, 5));
            s    = ($urandom_range(0, 1) == 1) ? W : int'($urandom_range(W, 32));
            ls   = s;
            rs   = s;
            if (mode == 4 && i < 23) ls = int'($urandom_range(2, W - 1));
            if (mode == 5 && i < 23) rs = int'($urandom_range(2, W - 1));
            send_frame(rl, rr, ls, rs, 1'($urandom()));
        end
        flush();
        end_check("random");

        send_frame(W'($urandom()), W'($urandom()), 16, 16, 1'b0);
        for (int j = 0; j < 8; j++) drive_slot(1'b0, 1'($urandom()));
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_reset_par", 64'(ADCDAT_PAR), 64'd0);
        chk("async_reset_valid", 64'(PAR_VALID), 64'd0);
        chk("async_reset_err", 64'(FRAME_ERR), 64'd0);
        par_hold = '0;
        for (int j = 0; j < 3; j++) drive_slot(1'b0, 1'($urandom()));
        RST_N = 1'b1;
        for (int j = 0; j < 5; j++) drive_slot(1'b0, 1'($urandom()));
        for (int j = 0; j < W; j++) drive_slot(1'b1, 1'($urandom()));
        send_frame(W'($urandom()), W'($urandom()), 16, 16, 1'b0);
        send_frame(W'($urandom()), W'($urandom()), 20, 24, 1'b1);
        flush();
        end_check("reset_resync");

`ifdef AUDIO_DESERIALIZER_ERRCNT_EN
        RST_N = 1'b0;
        par_hold = '0;
        drive_slot(1'b1, 1'b0);
        chk("errcnt_reset", 64'(ERR_CNT), 64'd0);
        RST_N = 1'b1;
        n_err   = 0;
        exp_err = 0;
        drive_slot(1'b1, 1'b0);
        for (int i = 0; i < 300; i++) send_frame(W'($urandom()), W'($urandom()), 3, 3, 1'b0);
        drive_slot(1'b0, 1'b0);
        chk("errcnt_saturated", 64'(ERR_CNT), 64'd255);
        for (int i = 0; i < 5; i++) send_frame(W'($urandom()), W'($urandom()), 3, 3, 1'b0);
        drive_slot(1'b0, 1'b0);
        chk("errcnt_holds", 64'(ERR_CNT), 64'd255);
        end_check("errcnt");
        RST_N = 1'b0;
        #1;
        chk("errcnt_cleared", 64'(ERR_CNT), 64'd0);
        par_hold = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
